// File: rtl/rand_gen_pkg.sv
// Shared constants, FSM state type and Galois tap table for the rand_gen sequence generator.
// Optional feature macro used elsewhere in this slice: RAND_GEN_PERIOD_CNT_EN.
package rand_pkg;

  localparam int MAX_WIDTH = 16;

  localparam int MODE_CNT  = 0;
  localparam int MODE_LFSR = 1;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } gen_state_t;

  // Right-shift Galois masks: bit k-1 is set for each x^k term of a primitive polynomial.
  function automatic logic [MAX_WIDTH-1:0] taps(input int width);
    logic [MAX_WIDTH-1:0] mask;
    mask = '0;
    case (width)
      3:       mask = 16'h0006;
      4:       mask = 16'h000C;
      5:       mask = 16'h0014;
      6:       mask = 16'h0030;
      7:       mask = 16'h0060;
      8:       mask = 16'h00B8;
      9:       mask = 16'h0110;
      10:      mask = 16'h0240;
      11:      mask = 16'h0500;
      12:      mask = 16'h0E08;
      13:      mask = 16'h1C80;
      14:      mask = 16'h3802;
      15:      mask = 16'h6000;
      16:      mask = 16'hD008;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rand_gen_if.sv
// Consumer-side bundle for rand_gen: seed load, sequence value, valid/ready and wrap pulse.
// Optional feature macro (top-level port, not in this bundle): RAND_GEN_PERIOD_CNT_EN.
interface rand_gen_if #(
  parameter int WIDTH = 8
);

  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_ready;
  logic             wrap;

  modport master (
    input  load,
    input  seed_in,
    input  q_ready,
    output q,
    output q_valid,
    output wrap
  );

  modport slave (
    output load,
    output seed_in,
    output q_ready,
    input  q,
    input  q_valid,
    input  wrap
  );

endinterface

// File: rtl/rand_gen_next.sv
// Combinational successor of the current sequence value: STEP add or Galois shift with lock-up guard.
// Optional feature macro (handled in the top): RAND_GEN_PERIOD_CNT_EN.
module rand_gen_next
  import rand_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = 1,
  parameter int SEED  = 1,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [MAX_WIDTH-1:0] TAPS_FULL = taps(WIDTH);
  localparam logic [WIDTH-1:0]     TAPS      = TAPS_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SEED_W    = WIDTH'(SEED);
  localparam logic [WIDTH-1:0]     STEP_W    = WIDTH'(STEP);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] summed;

  // A zero LFSR state would stick forever, so it is replaced by the seed.
  always_comb begin
    shifted = (cur >> 1) ^ (cur[0] ? TAPS : '0);
    summed  = cur + STEP_W;
    nxt     = summed;
    if (MODE == MODE_LFSR) begin
      nxt = (shifted == '0) ? SEED_W : shifted;
    end
  end

endmodule

// File: rtl/rand_gen.sv
// Sequence generator top: up-counter or Galois LFSR with seed load, valid/ready output and wrap pulse.
// Define RAND_GEN_PERIOD_CNT_EN to add the period_cnt output (advances since reset/load/wrap).
module rand_gen
  import rand_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = 1,
  parameter int SEED  = 1,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             clr,
`ifdef RAND_GEN_PERIOD_CNT_EN
  output logic [WIDTH:0]   period_cnt,
`endif
  rand_gen_if.master       bus
);

  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

  gen_state_t       state;
  gen_state_t       state_next;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] load_val;
  logic             q_valid;
  logic             wrap;
  logic             advance;

  rand_gen_next #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .SEED  (SEED),
    .STEP  (STEP)
  ) u_next (
    .cur (q),
    .nxt (nxt)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  // q_valid is held low for exactly one cycle after reset, then stays high.
  always_comb begin
    state_next = state;
    q_valid    = 1'b0;
    case (state)
      ST_RESET: state_next = ST_RUN;
      ST_RUN:   q_valid    = 1'b1;
      default:  state_next = ST_RESET;
    endcase
  end

  always_comb begin
    load_val = bus.seed_in;
    if (MODE == MODE_LFSR && bus.seed_in == '0) begin
      load_val = SEED_W;
    end
  end

  assign advance = q_valid & bus.q_ready & ~bus.load;

  // Load wins over the handshake; wrap compares against the start value of the current run.
  always_ff @(posedge clk) begin
    if (clr) begin
      q     <= SEED_W;
      start <= SEED_W;
      wrap  <= 1'b0;
    end else if (bus.load) begin
      q     <= load_val;
      start <= load_val;
      wrap  <= 1'b0;
    end else if (advance) begin
      q     <= nxt;
      wrap  <= (nxt == start);
    end else begin
      wrap  <= 1'b0;
    end
  end

`ifdef RAND_GEN_PERIOD_CNT_EN
  // Clears together with the wrap pulse so it reads 0 while wrap is high.
  always_ff @(posedge clk) begin
    if (clr || bus.load) begin
      period_cnt <= '0;
    end else if (advance) begin
      if (nxt == start) begin
        period_cnt <= '0;
      end else if (period_cnt != '1) begin
        period_cnt <= period_cnt + 1'b1;
      end
    end
  end
`endif

  assign bus.q       = q;
  assign bus.q_valid = q_valid;
  assign bus.wrap    = wrap;

endmodule

// File: tb/tb_rand_gen.sv
// Directed self-checking bench: WIDTH=3 LFSR instance and WIDTH=4 STEP=3 counter instance.
// Build with RAND_GEN_PERIOD_CNT_EN defined to also check period_cnt.
module tb_rand_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic l_clr;
  logic c_clr;
  int   checks = 0;
  int   errors = 0;

  rand_gen_if #(.WIDTH(3)) l_bus ();
  rand_gen_if #(.WIDTH(4)) c_bus ();

`ifdef RAND_GEN_PERIOD_CNT_EN
  logic [3:0] l_cnt;
  logic [4:0] c_cnt;
`endif

  rand_gen #(.WIDTH(3), .MODE(1), .SEED(1), .STEP(1)) u_lfsr (
    .clk        (clk),
    .clr        (l_clr),
`ifdef RAND_GEN_PERIOD_CNT_EN
    .period_cnt (l_cnt),
`endif
    .bus        (l_bus.master)
  );

  rand_gen #(.WIDTH(4), .MODE(0), .SEED(1), .STEP(3)) u_cnt (
    .clk        (clk),
    .clr        (c_clr),
`ifdef RAND_GEN_PERIOD_CNT_EN
    .period_cnt (c_cnt),
`endif
    .bus        (c_bus.master)
  );

  logic [2:0] lseq  [7]  = '{3'b110, 3'b011, 3'b111, 3'b101, 3'b100, 3'b010, 3'b001};
  logic [2:0] lseq2 [7]  = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b111, 3'b101};
  logic [3:0] cseq  [16] = '{4'd4, 4'd7, 4'd10, 4'd13, 4'd0, 4'd3, 4'd6, 4'd9,
                             4'd12, 4'd15, 4'd2, 4'd5, 4'd8, 4'd11, 4'd14, 4'd1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic c, input logic ld, input logic [2:0] seed,
                               input logic rdy);
    l_clr         = c;
    l_bus.load    = ld;
    l_bus.seed_in = seed;
    l_bus.q_ready = rdy;
    tick();
  endtask

  task automatic applyCounter(input logic c, input logic ld, input logic [3:0] seed,
                              input logic rdy);
    c_clr         = c;
    c_bus.load    = ld;
    c_bus.seed_in = seed;
    c_bus.q_ready = rdy;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    $display("[TB] rand_gen directed run");
    l_clr = 1'b1;  l_bus.load = 1'b0;  l_bus.seed_in = '0;  l_bus.q_ready = 1'b0;
    c_clr = 1'b1;  c_bus.load = 1'b0;  c_bus.seed_in = '0;  c_bus.q_ready = 1'b0;
    tick();
    checkOutput("lfsr_reset_q", l_bus.q, 1);
    checkOutput("lfsr_reset_valid", l_bus.q_valid, 0);
    checkOutput("lfsr_reset_wrap", l_bus.wrap, 0);
    checkOutput("cnt_reset_q", c_bus.q, 1);
    checkOutput("cnt_reset_valid", c_bus.q_valid, 0);
`ifdef RAND_GEN_PERIOD_CNT_EN
    checkOutput("lfsr_reset_cnt", l_cnt, 0);
`endif

    // First post-reset edge: valid rises, no advance even with ready high
    c_clr = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    checkOutput("lfsr_first_valid", l_bus.q_valid, 1);
    checkOutput("lfsr_first_q", l_bus.q, 1);
    checkOutput("cnt_first_valid", c_bus.q_valid, 1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
      checkOutput($sformatf("lfsr_seq_q[%0d]", i), l_bus.q, lseq[i]);
      checkOutput($sformatf("lfsr_seq_wrap[%0d]", i), l_bus.wrap, (i == 6) ? 1 : 0);
`ifdef RAND_GEN_PERIOD_CNT_EN
      checkOutput($sformatf("lfsr_seq_cnt[%0d]", i), l_cnt, (i == 6) ? 0 : i + 1);
`endif
    end

    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    checkOutput("lfsr_pre_hold_q0", l_bus.q, 3'b110);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    checkOutput("lfsr_pre_hold_q1", l_bus.q, 3'b011);

    // Backpressure: five stalled cycles
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);
      checkOutput($sformatf("lfsr_hold_q[%0d]", i), l_bus.q, 3'b011);
      checkOutput($sformatf("lfsr_hold_wrap[%0d]", i), l_bus.wrap, 0);
`ifdef RAND_GEN_PERIOD_CNT_EN
      checkOutput($sformatf("lfsr_hold_cnt[%0d]", i), l_cnt, 2);
`endif
    end
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    checkOutput("lfsr_resume_q", l_bus.q, 3'b111);
`ifdef RAND_GEN_PERIOD_CNT_EN
    checkOutput("lfsr_resume_cnt", l_cnt, 3);
`endif

    // Zero seed is replaced by SEED; load beats a simultaneous handshake
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b1);
    checkOutput("lfsr_zero_seed_q", l_bus.q, 3'b001);
    checkOutput("lfsr_zero_seed_wrap", l_bus.wrap, 0);
`ifdef RAND_GEN_PERIOD_CNT_EN
    checkOutput("lfsr_load_cnt", l_cnt, 0);
`endif
    applyStimulus(1'b0, 1'b1, 3'b101, 1'b1);
    checkOutput("lfsr_load101_q", l_bus.q, 3'b101);
    checkOutput("lfsr_load101_wrap", l_bus.wrap, 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
      checkOutput($sformatf("lfsr_seq2_q[%0d]", i), l_bus.q, lseq2[i]);
      checkOutput($sformatf("lfsr_seq2_wrap[%0d]", i), l_bus.wrap, (i == 6) ? 1 : 0);
`ifdef RAND_GEN_PERIOD_CNT_EN
      checkOutput($sformatf("lfsr_seq2_cnt[%0d]", i), l_cnt, (i == 6) ? 0 : i + 1);
`endif
    end

    // clr overrides load
    applyStimulus(1'b1, 1'b1, 3'b110, 1'b1);
    checkOutput("lfsr_clr_load_q", l_bus.q, 3'b001);
    checkOutput("lfsr_clr_load_valid", l_bus.q_valid, 0);
    checkOutput("lfsr_clr_load_wrap", l_bus.wrap, 0);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    checkOutput("lfsr_after_clr_valid", l_bus.q_valid, 1);
    checkOutput("lfsr_after_clr_q", l_bus.q, 3'b001);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    checkOutput("lfsr_after_clr_adv0", l_bus.q, 3'b110);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
    checkOutput("lfsr_after_clr_adv1", l_bus.q, 3'b011);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b1);
    checkOutput("lfsr_mid_clr_q", l_bus.q, 3'b001);
    checkOutput("lfsr_mid_clr_valid", l_bus.q_valid, 0);
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0);

    // Counter instance: idle so far, now 16 advances with STEP=3
    checkOutput("cnt_idle_q", c_bus.q, 1);
    for (int i = 0; i < 16; i++) begin
      applyCounter(1'b0, 1'b0, 4'd0, 1'b1);
      checkOutput($sformatf("cnt_seq_q[%0d]", i), c_bus.q, cseq[i]);
      checkOutput($sformatf("cnt_seq_wrap[%0d]", i), c_bus.wrap, (i == 15) ? 1 : 0);
`ifdef RAND_GEN_PERIOD_CNT_EN
      checkOutput($sformatf("cnt_seq_cnt[%0d]", i), c_cnt, (i == 15) ? 0 : i + 1);
`endif
    end
    applyCounter(1'b0, 1'b1, 4'd5, 1'b1);
    checkOutput("cnt_load_hs_q", c_bus.q, 5);
    checkOutput("cnt_load_hs_wrap", c_bus.wrap, 0);
    applyCounter(1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("cnt_after_load_q", c_bus.q, 8);
    applyCounter(1'b0, 1'b1, 4'd0, 1'b1);
    checkOutput("cnt_zero_load_q", c_bus.q, 0);
    applyCounter(1'b0, 1'b0, 4'd0, 1'b1);
    checkOutput("cnt_from_zero_q", c_bus.q, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
